// File: rtl/cms_ctrl_sequencer.sv
// Queues host control-register writes and replays each one to the monitoring block
// as a single setup / pulse / gap framed ctrl_write_enable strobe.
module cms_ctrl_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic                          flush,
  output logic [ADDR_WIDTH-1:0]         ctrl_addr,
  output logic [DATA_WIDTH-1:0]         ctrl_wdata,
  output logic                          ctrl_write_enable,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   issued_count
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SP > GAP_CYCLES) ? MAX_SP : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic                    push;
  logic                    pop;
  logic                    not_empty;
  logic                    cnt_last;

  // A full queue refuses a push even if the head pops on the same edge.
  assign cmd_ready = (fifo_level != LVL_W'(FIFO_DEPTH)) & ~flush;
  assign push      = cmd_valid & cmd_ready;
  assign not_empty = (fifo_level != '0);
  assign cnt_last  = (cnt == CNT_W'(1));
  assign pop       = (state == PULSE) & cnt_last & ~flush;
  assign busy      = (state != IDLE) | not_empty;

  // Command storage; contents need no reset, pointers and level guard them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cmd_addr;
      mem_data[wr_ptr] <= cmd_wdata;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Write-pulse sequencer; one down-counter reloaded on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      ctrl_addr         <= '0;
      ctrl_wdata        <= '0;
      ctrl_write_enable <= 1'b0;
      issued_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (not_empty && !flush) begin
            state      <= SETUP;
            cnt        <= CNT_W'(SETUP_CYCLES);
            ctrl_addr  <= mem_addr[rd_ptr];
            ctrl_wdata <= mem_data[rd_ptr];
          end
        end
        SETUP: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt_last) begin
            state             <= PULSE;
            cnt               <= CNT_W'(PULSE_CYCLES);
            ctrl_write_enable <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          // The rising edge is already out, so an aborted pulse still counts.
          if (flush || cnt_last) begin
            state             <= GAP;
            cnt               <= CNT_W'(GAP_CYCLES);
            ctrl_write_enable <= 1'b0;
            issued_count      <= issued_count + 16'd1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_last) begin
            if (not_empty && !flush) begin
              state      <= SETUP;
              cnt        <= CNT_W'(SETUP_CYCLES);
              ctrl_addr  <= mem_addr[rd_ptr];
              ctrl_wdata <= mem_data[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Randomized scoreboard bench: accepted commands queue up as expected writes and a
// negedge monitor matches every enable pulse, its timing and the status outputs.
module tb_cms_ctrl_sequencer;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int SC    = 1;
  localparam int PC    = 2;
  localparam int GC    = 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata;
  logic          ctrl_write_enable;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic [15:0]   issued_count;

  cms_ctrl_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .SETUP_CYCLES(SC), .PULSE_CYCLES(PC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .flush(flush),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(ctrl_write_enable), .busy(busy),
    .fifo_level(fifo_level), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            acc;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, advanced once per edge by the monitor.
  int            cyc = 0;
  int            pulse_left = 0;
  int            gap_left = 0;
  int            last_fall = -1000;
  int            stable = 0;
  int            exp_level = 0;
  int            rise_exp = 0;
  logic [15:0]   exp_issued = '0;
  logic          l_valid = 1'b0, l_ready = 1'b0, l_flush = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [DW-1:0] l_data = '0;
  logic          p_en = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  cmd_t          cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pulse_left = 0; gap_left = 0; last_fall = -1000; stable = 0;
      exp_issued = '0;
      l_valid = 1'b0; l_ready = 1'b0; l_flush = 1'b0; l_addr = '0; l_data = '0;
      p_en = 1'b0; p_addr = '0; p_data = '0;
    end else begin
      cyc++;
      // Effects of the edge just past.
      if (gap_left > 0) gap_left--;
      if (pulse_left > 0) begin
        pulse_left = l_flush ? 0 : pulse_left - 1;
        if (pulse_left == 0) begin
          exp_issued = exp_issued + 16'd1;
          gap_left   = GC;
          last_fall  = cyc;
        end
      end
      if (l_flush) exp_q.delete();
      else if (l_valid && l_ready) exp_q.push_back('{l_addr, l_data, cyc});

      if (ctrl_addr !== p_addr || ctrl_wdata !== p_data) begin
        chk("addr_change_with_enable", 64'(ctrl_write_enable | p_en), 64'd0);
        stable = 0;
      end else begin
        stable++;
      end

      if (pulse_left > 0) begin
        chk("enable_held", 64'(ctrl_write_enable), 64'd1);
      end else if (ctrl_write_enable && !p_en) begin
        chk("pulse_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("wr_addr", 64'(ctrl_addr), 64'(cur.a));
          chk("wr_data", 64'(ctrl_wdata), 64'(cur.d));
          rise_exp = cur.acc + 1 + SC;
          if (last_fall + GC + SC > rise_exp) rise_exp = last_fall + GC + SC;
          chk("rise_cycle", 64'(cyc), 64'(rise_exp));
          chk("setup_stable", 64'(stable >= SC), 64'd1);
        end
        pulse_left = PC;
      end else begin
        chk("enable_low", 64'(ctrl_write_enable), 64'd0);
      end

      exp_level = exp_q.size() + ((pulse_left > 0) ? 1 : 0);
      chk("fifo_level", 64'(fifo_level), 64'(exp_level));
      chk("issued_count", 64'(issued_count), 64'(exp_issued));
      chk("busy", 64'(busy), 64'(exp_level > 0 || gap_left > 0));
      chk("cmd_ready", 64'(cmd_ready), 64'(exp_level != DEPTH && !flush));

      l_valid = cmd_valid; l_ready = cmd_ready; l_flush = flush;
      l_addr = cmd_addr; l_data = cmd_wdata;
      p_en = ctrl_write_enable; p_addr = ctrl_addr; p_data = ctrl_wdata;
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic f);
    @(posedge clk); #1;
    cmd_valid = v; cmd_addr = a; cmd_wdata = d; flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0);
  endtask

  // Present a command and hold it until ready; it is taken on the following edge.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    drive(1'b1, a, d, 1'b0);
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready stuck low, required 1");
    end
  endtask

  task automatic wait_enable();
    int n = 0;
    do begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n++;
    end while (!ctrl_write_enable && n < 60);
    if (!ctrl_write_enable) begin
      checks++; errors++;
      $display("FAIL enable_timeout: ctrl_write_enable 0, required 1");
    end
  endtask

  initial begin
    int n;
    #12;
    chk("reset_addr", 64'(ctrl_addr), 64'd0);
    chk("reset_wdata", ctrl_wdata, 64'd0);
    chk("reset_enable", 64'(ctrl_write_enable), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_count", 64'(issued_count), 64'd0);
    @(negedge clk); #2 rst = 1'b0;
    #1 chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    // Single write.
    send(8'd2, 64'h8000_0000);
    idle(10);
    chk("single_count", 64'(issued_count), 64'd1);
    chk("single_busy", 64'(busy), 64'd0);

    // Back-to-back writes.
    send(8'd0, {$urandom, $urandom});
    send(8'd1, {$urandom, $urandom});
    send(8'd6, {$urandom, $urandom});
    idle(20);
    chk("b2b_count", 64'(issued_count), 64'd4);

    // Backpressure: six commands against a four-deep queue.
    for (int i = 0; i < 6; i++) send(AW'(i + 16), {$urandom, $urandom});
    idle(40);
    chk("bp_count", 64'(issued_count), 64'd10);

    // Flush during the first pulse of three queued writes.
    for (int i = 0; i < 3; i++) send(AW'(i + 32), {$urandom, $urandom});
    wait_enable();
    flush = 1'b1;
    idle(12);
    chk("flush_pulse_count", 64'(issued_count), 64'd11);
    chk("flush_pulse_level", 64'(fifo_level), 64'd0);
    chk("flush_pulse_busy", 64'(busy), 64'd0);

    // Flush while the single queued write is in setup.
    send(8'd40, {$urandom, $urandom});
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    idle(12);
    chk("flush_setup_count", 64'(issued_count), 64'd11);
    chk("flush_setup_busy", 64'(busy), 64'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(0, 9) < 6), AW'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 39) == 0));
    n = 0;
    do begin
      idle(1);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    chk("random_drained", 64'(exp_q.size()), 64'd0);
    chk("random_idle", 64'(busy), 64'd0);

    // Asynchronous reset while the enable is high.
    send(8'd7, {$urandom, $urandom});
    wait_enable();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enable", 64'(ctrl_write_enable), 64'd0);
    chk("async_rst_addr", 64'(ctrl_addr), 64'd0);
    chk("async_rst_wdata", ctrl_wdata, 64'd0);
    chk("async_rst_count", 64'(issued_count), 64'd0);
    chk("async_rst_level", 64'(fifo_level), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk); #2 rst = 1'b0;
    #1 chk("ready_after_async_reset", 64'(cmd_ready), 64'd1);
    send(8'd9, 64'h1234_5678_9abc_def0);
    idle(10);
    chk("post_reset_count", 64'(issued_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cms_ctrl_sequencer.md
# cms_ctrl_sequencer

- Queues control-register writes (address + data) from a host-side valid/ready command port.
- Replays each queued write onto the continuous monitoring system's `ctrl_addr` / `ctrl_wdata` / `ctrl_write_enable` port.
- Every write becomes one clean low→high→low pulse with a programmable setup, pulse width and gap, so it is safe for the posedge-triggered control mode.
- Sits between the processor-facing control path and the monitoring block, so multi-register configuration sequences need no software pacing.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, control address width.
- `DATA_WIDTH`, 64, control data width.
- `FIFO_DEPTH`, 4, command queue depth; power of two, ≥2.
- `SETUP_CYCLES`, 1, cycles addr/data are stable with enable low before the pulse; ≥1.
- `PULSE_CYCLES`, 2, cycles `ctrl_write_enable` is high; ≥1.
- `GAP_CYCLES`, 1, cycles enable is low after the pulse; ≥1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  queue can accept.
- `cmd_addr`  in  ADDR_WIDTH  target control address.
- `cmd_wdata`  in  DATA_WIDTH  control data.
- `flush`  in  1  synchronous queue clear / abort.
- `ctrl_addr`  out  ADDR_WIDTH  registered, to monitoring block.
- `ctrl_wdata`  out  DATA_WIDTH  registered, to monitoring block.
- `ctrl_write_enable`  out  1  registered write pulse.
- `busy`  out  1  state ≠ IDLE or queue non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries queued.
- `issued_count`  out  16  writes delivered; wraps 65535→0.

## Operation
- **Queue**
  - Circular FIFO with read/write pointers and a level counter.
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = (fifo_level != FIFO_DEPTH) & ~flush`, combinational.
  - A full queue refuses a push even when a pop happens in the same cycle.
  - Simultaneous push and pop leaves `fifo_level` unchanged.
- **FSM states:** IDLE, SETUP, PULSE, GAP. One down-counter is loaded on each state entry.
  - IDLE → SETUP when the queue is non-empty. On that edge, `ctrl_addr` / `ctrl_wdata` load from the queue head.
  - SETUP → PULSE after SETUP_CYCLES; `ctrl_write_enable` goes to 1.
  - PULSE → GAP after PULSE_CYCLES, with these actions on the same edge:
    - `ctrl_write_enable` goes to 0.
    - The head is popped.
    - `issued_count` increments.
  - GAP → SETUP (loading the new head) if the queue is non-empty, otherwise GAP → IDLE.
- `ctrl_addr` / `ctrl_wdata` hold their last value in IDLE and GAP. They change only on entry to SETUP.
- **Flush** (sampled each edge; no push is accepted that cycle). On the flush edge, the queue is emptied (pointers and level to 0), plus per-state action:
  - In IDLE: nothing further.
  - In SETUP: go to IDLE; no pulse is issued and there is no count.
  - In PULSE: go to GAP now. The enable drops and `issued_count` increments, because the rising edge was already delivered.
  - In GAP: finish the GAP, then go to IDLE.
- **Reset** (asynchronous, any time, including mid-pulse):
  - State = IDLE.
  - Queue emptied.
  - `ctrl_addr = 0`, `ctrl_wdata = 0`, `ctrl_write_enable = 0`.
  - `issued_count = 0`, `busy = 0`, `fifo_level = 0`.
  - `cmd_ready = 1` once `rst` is released.

## Timing
- Push accepted at edge E0 → SETUP entered at E1 → enable high from E1+SETUP_CYCLES → enable low at E1+SETUP_CYCLES+PULSE_CYCLES.
- With defaults, enable rises 2 edges after acceptance and is high for exactly 2 cycles.
- Back-to-back throughput: one write per SETUP+PULSE+GAP cycles (4 with defaults). The enable is never high in consecutive pulses without at least GAP_CYCLES low between them.
- Enable rises only after addr/data have been stable for ≥SETUP_CYCLES cycles.
- Enable never changes in the same cycle as addr/data.
- `issued_count` and `fifo_level` update on the pulse-ending edge.

## Test plan
- **Single write:** reset, push (addr 2, data 0x8000_0000) at E0.
  - `ctrl_addr = 2` from E1.
  - Enable high for edges E2–E3, low at E4.
  - `issued_count = 1`; `busy` low after GAP.
- **Back-to-back:** push addrs 0, 1, 6 on consecutive cycles.
  - Three enable pulses, rising edges 4 cycles apart, each 2 cycles wide.
  - Addr/data match each command in order; `issued_count = 3`.
- **Backpressure:** hold `cmd_valid` for 6 commands while idle-blocked.
  - `cmd_ready` drops when `fifo_level = 4`; it is not reasserted in the cycle of a pop.
  - All 6 writes are eventually issued in order.
- **Flush mid-pulse:** queue 3 commands, assert `flush` on the 2nd cycle of the first pulse.
  - Enable drops next edge; `issued_count = 1`, `fifo_level = 0`.
  - Back to IDLE after 1 GAP cycle; no further pulses.
- **Flush in SETUP:** queue 1 command, flush during SETUP.
  - Enable never rises; `issued_count = 0`, IDLE.
- **Async reset mid-pulse:** assert `rst` between edges while enable is high.
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - A new push after release issues normally with `issued_count = 1`.
